// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard sequencer: sequencer state encoding,
// default HI/LO unit latencies and the stall-priority enumeration.
package hazard_pkg;

    // Sequencer state encoding
    localparam logic ST_RUN      = 1'b0;
    localparam logic ST_MEM_HOLD = 1'b1;

    // Default HI/LO unit latencies and countdown width
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;
    localparam int CNT_W_DEF   = 6;

    // Which stall source wins in a given cycle, highest priority first
    typedef enum logic [2:0] {
        PRIO_MEM   = 3'd0,
        PRIO_FLUSH = 3'd1,
        PRIO_MD    = 3'd2,
        PRIO_LU    = 3'd3,
        PRIO_NONE  = 3'd4
    } prio_e;

endpackage

// File: rtl/md_latency_counter.sv
// Busy tracker for the multi-cycle HI/LO (mul/div) unit. A start while idle
// loads the operation latency minus one; the count then runs down to zero
// regardless of pipeline stalls, because the unit runs independently.
module md_latency_counter
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic [CNT_W-1:0] count;

    // Load on an accepted start, otherwise count down while nonzero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start && (count == '0)) begin
            count <= is_div ? DIV_LOAD : MUL_LOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

    // A second mul/div issued while the unit is busy is a protocol error
    assert property (@(posedge clk) disable iff (!rst_n) !(start && busy));

endmodule

// File: rtl/hazard_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline. Prioritises memory
// wait, branch flush, mul/div wait and load-use in one place and drives the
// PC / IF-ID enables, the ID/EX bubble select, the IF/ID flush and the
// back-end hold. Outputs are combinational from registered state and the
// current inputs, so every stall takes effect in the cycle of its cause.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush perf counters;
// without it both counter ports read 0.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lu_hazard,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        PCWrite,
    output logic        IF2IDWrite,
    output logic        con_mux,
    output logic        IF2IDFlush,
    output logic        pipe_hold,
    output logic        md_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    logic  state;
    logic  branchPend;
    logic  memWait;
    prio_e prioLvl;

    md_latency_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) mdCounter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (md_is_div),
        .busy   (md_busy)
    );

    // Pick the winning stall source for this cycle
    always_comb begin
        memWait = ((state == ST_MEM_HOLD) || (dmem_req && !dmem_ready)) && !dmem_ready;
        prioLvl = PRIO_NONE;
        if (memWait)                          prioLvl = PRIO_MEM;
        else if (branch_taken || branchPend)  prioLvl = PRIO_FLUSH;
        else if (md_use && md_busy)           prioLvl = PRIO_MD;
        else if (lu_hazard)                   prioLvl = PRIO_LU;
    end

    // Translate the winning source into pipeline enables
    always_comb begin
        PCWrite    = 1'b1;
        IF2IDWrite = 1'b1;
        con_mux    = 1'b1;
        IF2IDFlush = 1'b0;
        pipe_hold  = 1'b0;
        case (prioLvl)
            PRIO_MEM: begin
                // Freeze everything in place; no bubble is inserted
                PCWrite    = 1'b0;
                IF2IDWrite = 1'b0;
                pipe_hold  = 1'b1;
            end
            PRIO_FLUSH: begin
                IF2IDFlush = 1'b1;
            end
            PRIO_MD, PRIO_LU: begin
                PCWrite    = 1'b0;
                IF2IDWrite = 1'b0;
                con_mux    = 1'b0;
            end
            default: ;
        endcase
    end

    // Memory-wait FSM and the branch remembered across a freeze
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            branchPend <= 1'b0;
        end else begin
            case (state)
                ST_RUN:      if (dmem_req && !dmem_ready) state <= ST_MEM_HOLD;
                ST_MEM_HOLD: if (dmem_ready)              state <= ST_RUN;
                default:                                  state <= ST_RUN;
            endcase
            if (memWait) begin
                branchPend <= branchPend || branch_taken;
            end else if (prioLvl == PRIO_FLUSH) begin
                branchPend <= 1'b0;
            end
        end
    end

    // A flush and a back-end freeze can never be issued together
    assert property (@(posedge clk) disable iff (!rst_n) !(IF2IDFlush && pipe_hold));

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    // Saturating counts of PC-stalled cycles and issued flushes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!PCWrite && (stallCnt != 32'hFFFF_FFFF)) stallCnt <= stallCnt + 32'd1;
            if (IF2IDFlush && (flushCnt != 32'hFFFF_FFFF)) flushCnt <= flushCnt + 32'd1;
        end
    end

    assign stall_cycles = stallCnt;
    assign flush_count  = flushCnt;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: reset, load-use, mul/div busy,
// memory freeze with a pending branch, priority and reset during a freeze.
module tb_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        luHazard, mdStart, mdIsDiv, mdUse, dmemReq, dmemReady, branchTaken;
    logic        pcWrite, if2idWrite, conMux, if2idFlush, pipeHold, mdBusy;
    logic [31:0] stallCycles, flushCount;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .lu_hazard    (luHazard),
        .md_start     (mdStart),
        .md_is_div    (mdIsDiv),
        .md_use       (mdUse),
        .dmem_req     (dmemReq),
        .dmem_ready   (dmemReady),
        .branch_taken (branchTaken),
        .PCWrite      (pcWrite),
        .IF2IDWrite   (if2idWrite),
        .con_mux      (conMux),
        .IF2IDFlush   (if2idFlush),
        .pipe_hold    (pipeHold),
        .md_busy      (mdBusy),
        .stall_cycles (stallCycles),
        .flush_count  (flushCount)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step to just after the next edge, apply inputs, let outputs settle
    task automatic applyCycle(input logic lu, input logic ms, input logic mdiv, input logic mu,
                              input logic dreq, input logic drdy, input logic br);
        @(posedge clk);
        #1;
        luHazard = lu; mdStart = ms; mdIsDiv = mdiv; mdUse = mu;
        dmemReq = dreq; dmemReady = drdy; branchTaken = br;
        #2;
    endtask

    // Check the five pipeline-control outputs in one go
    task automatic checkCtl(input string tag, input logic pc, input logic ifw, input logic cm,
                            input logic fl, input logic ph);
        checkVal({tag, ".PCWrite"},    32'(pcWrite),    32'(pc));
        checkVal({tag, ".IF2IDWrite"}, 32'(if2idWrite), 32'(ifw));
        checkVal({tag, ".con_mux"},    32'(conMux),     32'(cm));
        checkVal({tag, ".IF2IDFlush"}, 32'(if2idFlush), 32'(fl));
        checkVal({tag, ".pipe_hold"},  32'(pipeHold),   32'(ph));
    endtask

    int busyStalls;
    logic [31:0] expStall, expFlush;

    initial begin
`ifdef HAZARD_PERF_EN
        expStall = 32'd38;
        expFlush = 32'd2;
`else
        expStall = 32'd0;
        expFlush = 32'd0;
`endif
        rstN = 1'b0;
        luHazard = 0; mdStart = 0; mdIsDiv = 0; mdUse = 0;
        dmemReq = 0; dmemReady = 0; branchTaken = 0;

        // Reset then idle
        repeat (2) @(posedge clk);
        applyCycle(0, 0, 0, 0, 0, 0, 0);
        checkCtl("rst", 1, 1, 1, 0, 0);
        checkVal("rst.md_busy", 32'(mdBusy), 32'd0);
        checkVal("rst.stall_cycles", stallCycles, 32'd0);
        checkVal("rst.flush_count", flushCount, 32'd0);
        rstN = 1'b1;
        applyCycle(0, 0, 0, 0, 0, 0, 0);
        checkCtl("idle", 1, 1, 1, 0, 0);

        // Load-use: one bubble, then normal flow
        applyCycle(1, 0, 0, 0, 0, 0, 0);
        checkCtl("lu", 0, 0, 0, 0, 0);
        applyCycle(0, 0, 0, 0, 0, 0, 0);
        checkCtl("luAfter", 1, 1, 1, 0, 0);

        // Multiply: 3 busy cycles with bubbles, released on the 4th
        applyCycle(0, 1, 0, 0, 0, 0, 0);
        checkVal("mulIssue.md_busy", 32'(mdBusy), 32'd0);
        checkVal("mulIssue.PCWrite", 32'(pcWrite), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyCycle(0, 0, 0, 1, 0, 0, 0);
            checkVal("mulWait.md_busy", 32'(mdBusy), 32'd1);
            checkCtl("mulWait", 0, 0, 0, 0, 0);
        end
        applyCycle(0, 0, 0, 1, 0, 0, 0);
        checkVal("mulDone.md_busy", 32'(mdBusy), 32'd0);
        checkCtl("mulDone", 1, 1, 1, 0, 0);

        // Divide: 31 busy stall cycles
        applyCycle(0, 1, 1, 0, 0, 0, 0);
        busyStalls = 0;
        for (int i = 0; i < 33; i++) begin
            applyCycle(0, 0, 0, 1, 0, 0, 0);
            if (mdBusy && !pcWrite && !conMux) busyStalls++;
        end
        checkVal("divBusyCycles", 32'(busyStalls), 32'd31);
        checkVal("divDone.md_busy", 32'(mdBusy), 32'd0);

        // Memory wait for 3 cycles, branch arrives in the 2nd
        applyCycle(0, 0, 0, 0, 1, 0, 0);
        checkCtl("memW1", 0, 0, 1, 0, 1);
        applyCycle(0, 0, 0, 0, 1, 0, 1);
        checkCtl("memW2", 0, 0, 1, 0, 1);
        applyCycle(0, 0, 0, 0, 1, 0, 0);
        checkCtl("memW3", 0, 0, 1, 0, 1);
        applyCycle(0, 0, 0, 0, 1, 1, 0);
        checkCtl("memReady", 1, 1, 1, 1, 0);
        applyCycle(0, 0, 0, 0, 0, 0, 0);
        checkCtl("memAfter", 1, 1, 1, 0, 0);

        // Flush beats load-use
        applyCycle(1, 0, 0, 0, 0, 0, 1);
        checkCtl("prio", 1, 1, 1, 1, 0);
        applyCycle(0, 0, 0, 0, 0, 0, 0);
        checkCtl("prioAfter", 1, 1, 1, 0, 0);
        checkVal("perf.stall_cycles", stallCycles, expStall);
        checkVal("perf.flush_count", flushCount, expFlush);

        // Reset in the middle of a freeze with a pending branch
        applyCycle(0, 0, 0, 0, 1, 0, 0);
        applyCycle(0, 0, 0, 0, 1, 0, 1);
        checkCtl("holdBeforeRst", 0, 0, 1, 0, 1);
        rstN = 1'b0;
        applyCycle(0, 0, 0, 0, 0, 0, 0);
        rstN = 1'b1;
        applyCycle(0, 0, 0, 0, 0, 0, 0);
        checkCtl("afterRst", 1, 1, 1, 0, 0);
        checkVal("afterRst.stall_cycles", stallCycles, 32'd0);
        checkVal("afterRst.flush_count", flushCount, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
